keypad_scanner_param: RTL and testbench

//  Parametrised matrix-keypad scanner with per-key debounce. Drives one column at a

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/keypad_scanner_param.sv | 176 +++++++++++++++++
 tb/tb_keypad_scanner_param.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding and row-vector helpers for the keypad scanner
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN       = 3'd0,
        DB_PRESS   = 3'd1,
        HELD       = 3'd2,
        DB_RELEASE = 3'd3,
        WAIT_CLR   = 3'd4
    } scan_state_t;

    // Index of the lowest set bit; callers only use it on one-hot vectors.
    function automatic int onehot_idx(input logic [31:0] vec);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous level inputs
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner_param.sv
// rtl/keypad_scanner_param.sv - column-scanning keypad reader with press/release debounce
module keypad_scanner_param
    import keypad_pkg::*;
#(
    parameter  int NUM_ROWS        = 4,
    parameter  int NUM_COLS        = 4,
    parameter  int SETTLE_CYCLES   = 3,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int CODE_W          = (NUM_ROWS * NUM_COLS > 1) ? $clog2(NUM_ROWS * NUM_COLS) : 1
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [NUM_ROWS-1:0] row_i,
    output logic [NUM_COLS-1:0] col_o,
    output logic [CODE_W-1:0]   key_code_o,
    output logic                key_press_o,
    output logic                key_release_o,
    output logic                key_held_o,
    output logic                multi_err_o
);

    localparam int RI_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int CI_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [ST_W-1:0]     ST_LAST     = ST_W'(SETTLE_CYCLES - 1);
    localparam logic [DB_W-1:0]     DB_MAX      = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]     DB_CLR_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CI_W-1:0]     COL_LAST    = CI_W'(NUM_COLS - 1);
    localparam logic [NUM_COLS-1:0] COL0        = NUM_COLS'(1);

    logic [NUM_ROWS-1:0] rows_s;

    scan_state_t         state_q, state_d;
    logic [CI_W-1:0]     col_idx_q, col_idx_d, col_next;
    logic [NUM_COLS-1:0] col_q;
    logic [ST_W-1:0]     settle_q, settle_d;
    logic [DB_W-1:0]     db_q, db_d;
    logic [RI_W-1:0]     row_idx_q, row_idx_d;
    logic [NUM_ROWS-1:0] latched_q, latched_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                held_q, held_d;
    logic                press_q, press_d;
    logic                release_q, release_d;
    logic                multi_q, multi_d;
    int                  code_int;

    sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk  (clk),
        .nrst (nrst),
        .d_i  (row_i),
        .q_o  (rows_s)
    );

    assign col_next = (col_idx_q == COL_LAST) ? '0 : col_idx_q + CI_W'(1);
    assign code_int = int'(row_idx_q) * NUM_COLS + int'(col_idx_q);

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        settle_d  = settle_q;
        db_d      = db_q;
        row_idx_d = row_idx_q;
        latched_d = latched_q;
        code_d    = code_q;
        held_d    = held_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        multi_d   = 1'b0;
        case (state_q)
            SCAN: begin
                if (settle_q == ST_LAST) begin
                    settle_d = '0;
                    if (rows_s == '0) begin
                        col_idx_d = col_next;
                    end else if (is_onehot(32'(rows_s))) begin
                        row_idx_d = RI_W'(onehot_idx(32'(rows_s)));
                        latched_d = rows_s;
                        db_d      = DB_W'(1);
                        state_d   = DB_PRESS;
                    end else begin
                        multi_d = 1'b1;
                        db_d    = '0;
                        state_d = WAIT_CLR;
                    end
                end else begin
                    settle_d = settle_q + ST_W'(1);
                end
            end
            DB_PRESS: begin
                // Any disturbance restarts the settle window on the same column.
                if (rows_s != latched_q) begin
                    settle_d = '0;
                    state_d  = SCAN;
                end else if (db_q == DB_MAX) begin
                    code_d  = CODE_W'(code_int);
                    press_d = 1'b1;
                    held_d  = 1'b1;
                    state_d = HELD;
                end else begin
                    db_d = db_q + DB_W'(1);
                end
            end
            HELD: begin
                if (rows_s == '0) begin
                    db_d    = DB_W'(1);
                    state_d = DB_RELEASE;
                end
            end
            DB_RELEASE: begin
                if (rows_s != '0) begin
                    state_d = HELD;
                end else if (db_q == DB_MAX) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    col_idx_d = col_next;
                    settle_d  = '0;
                    state_d   = SCAN;
                end else begin
                    db_d = db_q + DB_W'(1);
                end
            end
            WAIT_CLR: begin
                if (rows_s != '0) begin
                    db_d = '0;
                end else if (db_q == DB_CLR_LAST) begin
                    col_idx_d = col_next;
                    settle_d  = '0;
                    state_d   = SCAN;
                end else begin
                    db_d = db_q + DB_W'(1);
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= SCAN;
            col_idx_q <= '0;
            col_q     <= COL0;
            settle_q  <= '0;
            db_q      <= '0;
            row_idx_q <= '0;
            latched_q <= '0;
            code_q    <= '0;
            held_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            col_q     <= COL0 << col_idx_d;
            settle_q  <= settle_d;
            db_q      <= db_d;
            row_idx_q <= row_idx_d;
            latched_q <= latched_d;
            code_q    <= code_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            multi_q   <= multi_d;
        end
    end

    assign col_o         = col_q;
    assign key_code_o    = code_q;
    assign key_press_o   = press_q;
    assign key_release_o = release_q;
    assign key_held_o    = held_q;
    assign multi_err_o   = multi_q;

endmodule

// File: tb/tb_keypad_scanner_param.sv
// tb/tb_keypad_scanner_param.sv - self-checking bench with a keypad matrix model and timing rules
module tb_keypad_scanner_param;

    localparam int S = 3;
    localparam int D = 4;
    localparam int PRESS_LAT = S + D;      // from the edge that drives the key's column
    localparam int REL_LAT   = 2 + 1 + D;  // sync, HELD sees zero, D release samples
    localparam int CLR_LAT   = 2 + D;      // sync, D zero samples in WAIT_CLR

    logic       clk = 1'b0;
    logic       nrst;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key_code_o;
    logic       key_press_o, key_release_o, key_held_o, multi_err_o;

    logic [3:0] key_m [4];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int press_cnt = 0, release_cnt = 0, err_cnt = 0, overlap_cnt = 0, bad_code_cnt = 0;
    logic [3:0] prev_code = 4'd0;
    int rst_rel;

    keypad_scanner_param #(
        .NUM_ROWS(4), .NUM_COLS(4), .SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .nrst(nrst), .row_i(row_i), .col_o(col_o), .key_code_o(key_code_o),
        .key_press_o(key_press_o), .key_release_o(key_release_o),
        .key_held_o(key_held_o), .multi_err_o(multi_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A pressed key shorts its row to its column while that column is driven.
    always_comb begin
        for (int r = 0; r < 4; r++) row_i[r] = |(key_m[r] & col_o);
    end

    always @(posedge clk) begin
        if (key_press_o)   press_cnt   <= press_cnt + 1;
        if (key_release_o) release_cnt <= release_cnt + 1;
        if (multi_err_o)   err_cnt     <= err_cnt + 1;
        if ((int'(key_press_o) + int'(key_release_o) + int'(multi_err_o)) > 1)
            overlap_cnt <= overlap_cnt + 1;
        if (nrst && key_code_o !== prev_code && !key_press_o)
            bad_code_cnt <= bad_code_cnt + 1;
        prev_code <= key_code_o;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) key_m[r] = 4'b0;
    endtask

    task automatic leave_col(input logic [3:0] tcol);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (col_o != tcol) break;
        end
    endtask

    task automatic wait_col(input logic [3:0] tcol, output int t, output bit ok);
        ok = 1'b0;
        t = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (col_o == tcol) begin ok = 1'b1; t = cyc; break; end
        end
    endtask

    task automatic wait_pulse(input int which, output int t, output bit ok);
        logic sig;
        ok = 1'b0;
        t = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            sig = (which == 0) ? key_press_o : (which == 1) ? key_release_o : multi_err_o;
            if (sig) begin ok = 1'b1; t = cyc; break; end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        clear_keys();
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (col_o !== 4'b0001) begin errors++; $display("FAIL reset_col: got %b want 0001", col_o); end
        checks++; if (key_code_o !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", key_code_o); end
        checks++; if ({key_press_o, key_release_o, multi_err_o} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b want 000", {key_press_o, key_release_o, multi_err_o}); end
        checks++; if (key_held_o !== 1'b0) begin errors++; $display("FAIL reset_held: got %b want 0", key_held_o); end
        nrst = 1'b1;
        rst_rel = cyc;
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            exp = 4'b0001 << (((cyc - rst_rel) / S) % 4);
            checks++; if (col_o !== exp) begin
                errors++; $display("FAIL idle_col: cycle %0d got %b want %b", cyc, col_o, exp); end
        end
        checks++; if (press_cnt + release_cnt + err_cnt != 0) begin
            errors++; $display("FAIL idle_pulses: got %0d pulses want 0", press_cnt + release_cnt + err_cnt); end
    endtask

    task automatic test_press_release();
        int r, c, e0, tp, tr, rc, p0, r0;
        bit ok;
        logic [3:0] tcol, ncol;
        for (int it = 0; it < 4; it++) begin
            r = (it == 0) ? 2 : $urandom_range(0, 3);
            c = (it == 0) ? 1 : $urandom_range(0, 3);
            tcol = 4'b0001 << c;
            ncol = 4'b0001 << ((c + 1) % 4);
            p0 = press_cnt; r0 = release_cnt;
            leave_col(tcol);
            key_m[r][c] = 1'b1;
            wait_col(tcol, e0, ok);
            wait_pulse(0, tp, ok);
            checks++; if (!ok || tp != e0 + PRESS_LAT) begin
                errors++; $display("FAIL press_time: r%0d c%0d got cycle %0d want %0d", r, c, tp - e0, PRESS_LAT); end
            checks++; if (key_code_o !== 4'(r * 4 + c)) begin
                errors++; $display("FAIL press_code: got %0d want %0d", key_code_o, r * 4 + c); end
            checks++; if (key_held_o !== 1'b1) begin errors++; $display("FAIL press_held: got %b want 1", key_held_o); end
            @(negedge clk);
            checks++; if (key_press_o !== 1'b0) begin errors++; $display("FAIL press_width: got %b want 0", key_press_o); end
            idle($urandom_range(5, 30));
            rc = cyc;
            key_m[r][c] = 1'b0;
            wait_pulse(1, tr, ok);
            checks++; if (!ok || tr != rc + REL_LAT) begin
                errors++; $display("FAIL release_time: got %0d want %0d", tr - rc, REL_LAT); end
            checks++; if (key_held_o !== 1'b0 || col_o !== ncol) begin
                errors++; $display("FAIL release_state: held %b col %b want held 0 col %b", key_held_o, col_o, ncol); end
            checks++; if (key_code_o !== 4'(r * 4 + c)) begin
                errors++; $display("FAIL release_code: got %0d want %0d", key_code_o, r * 4 + c); end
            idle(2);
            checks++; if (press_cnt - p0 != 1 || release_cnt - r0 != 1) begin
                errors++; $display("FAIL press_counts: press %0d release %0d want 1 1", press_cnt - p0, release_cnt - r0); end
        end
    endtask

    task automatic test_bounce();
        int r, c, b, e0, tp, tr, p0;
        bit ok;
        logic [3:0] tcol;
        for (int it = 0; it < 3; it++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            b = $urandom_range(1, 4);
            tcol = 4'b0001 << c;
            p0 = press_cnt;
            leave_col(tcol);
            key_m[r][c] = 1'b1;
            wait_col(tcol, e0, ok);
            while (cyc < e0 + b) @(negedge clk);
            key_m[r][c] = 1'b0;
            @(negedge clk);
            key_m[r][c] = 1'b1;
            // The dropped sample lands in the press debounce; rescan restarts on the next edge.
            wait_pulse(0, tp, ok);
            checks++; if (!ok || tp != e0 + b + 3 + PRESS_LAT) begin
                errors++; $display("FAIL bounce_time: b %0d got %0d want %0d", b, tp - e0, b + 3 + PRESS_LAT); end
            checks++; if (key_code_o !== 4'(r * 4 + c)) begin
                errors++; $display("FAIL bounce_code: got %0d want %0d", key_code_o, r * 4 + c); end
            idle(2);
            checks++; if (press_cnt - p0 != 1) begin
                errors++; $display("FAIL bounce_count: got %0d presses want 1", press_cnt - p0); end
            key_m[r][c] = 1'b0;
            wait_pulse(1, tr, ok);
            checks++; if (!ok) begin errors++; $display("FAIL bounce_release: got none want 1"); end
        end
    endtask

    task automatic test_multi();
        int c, ra, rb, e0, tp, rc, tn, p0, m0;
        bit ok;
        logic [3:0] tcol, ncol;
        for (int it = 0; it < 3; it++) begin
            c  = (it == 0) ? 0 : $urandom_range(0, 3);
            ra = (it == 0) ? 0 : $urandom_range(0, 3);
            rb = (it == 0) ? 3 : (ra + $urandom_range(1, 3)) % 4;
            tcol = 4'b0001 << c;
            ncol = 4'b0001 << ((c + 1) % 4);
            p0 = press_cnt; m0 = err_cnt;
            leave_col(tcol);
            key_m[ra][c] = 1'b1;
            key_m[rb][c] = 1'b1;
            wait_col(tcol, e0, ok);
            wait_pulse(2, tp, ok);
            checks++; if (!ok || tp != e0 + S) begin
                errors++; $display("FAIL multi_time: got %0d want %0d", tp - e0, S); end
            idle($urandom_range(5, 20));
            checks++; if (col_o !== tcol) begin errors++; $display("FAIL multi_hold_col: got %b want %b", col_o, tcol); end
            rc = cyc;
            key_m[ra][c] = 1'b0;
            key_m[rb][c] = 1'b0;
            wait_col(ncol, tn, ok);
            checks++; if (!ok || tn != rc + CLR_LAT) begin
                errors++; $display("FAIL multi_resume: got %0d want %0d", tn - rc, CLR_LAT); end
            idle(2);
            checks++; if (press_cnt != p0 || err_cnt - m0 != 1) begin
                errors++; $display("FAIL multi_counts: press %0d err %0d want 0 1", press_cnt - p0, err_cnt - m0); end
        end
    endtask

    task automatic test_second_key();
        int r, r2, c, tp, tr, p0, r0;
        bit ok;
        logic [3:0] tcol;
        r  = $urandom_range(0, 3);
        r2 = (r + $urandom_range(1, 3)) % 4;
        c  = $urandom_range(0, 3);
        tcol = 4'b0001 << c;
        leave_col(tcol);
        key_m[r][c] = 1'b1;
        wait_pulse(0, tp, ok);
        checks++; if (!ok) begin errors++; $display("FAIL second_press: got none want 1"); end
        idle(2);
        p0 = press_cnt; r0 = release_cnt;
        key_m[r2][c] = 1'b1;
        idle($urandom_range(10, 20));
        key_m[r2][c] = 1'b0;
        idle(15);
        checks++; if (press_cnt != p0 || release_cnt != r0) begin
            errors++; $display("FAIL second_pulses: press %0d release %0d want 0 0", press_cnt - p0, release_cnt - r0); end
        checks++; if (key_held_o !== 1'b1 || key_code_o !== 4'(r * 4 + c)) begin
            errors++; $display("FAIL second_state: held %b code %0d want 1 %0d", key_held_o, key_code_o, r * 4 + c); end
        key_m[r][c] = 1'b0;
        wait_pulse(1, tr, ok);
        checks++; if (!ok) begin errors++; $display("FAIL second_release: got none want 1"); end
    endtask

    task automatic test_reset_mid_press();
        int r, c, tp, r0;
        bit ok;
        r = $urandom_range(0, 3);
        c = $urandom_range(0, 3);
        leave_col(4'b0001 << c);
        key_m[r][c] = 1'b1;
        wait_pulse(0, tp, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_press: got none want 1"); end
        idle($urandom_range(3, 10));
        r0 = release_cnt;
        nrst = 1'b0;
        @(negedge clk);
        checks++; if (col_o !== 4'b0001 || key_held_o !== 1'b0 || key_release_o !== 1'b0 || key_code_o !== 4'd0) begin
            errors++; $display("FAIL rst_state: col %b held %b rel %b code %0d want 0001 0 0 0",
                               col_o, key_held_o, key_release_o, key_code_o); end
        clear_keys();
        idle(2);
        nrst = 1'b1;
        idle(30);
        checks++; if (release_cnt != r0) begin
            errors++; $display("FAIL rst_release: got %0d release pulses want 0", release_cnt - r0); end
    endtask

    task automatic test_monitors();
        checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL overlap: got %0d want 0", overlap_cnt); end
        checks++; if (bad_code_cnt != 0) begin errors++; $display("FAIL code_change: got %0d want 0", bad_code_cnt); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press_release();
        test_bounce();
        test_multi();
        test_second_key();
        test_reset_mid_press();
        test_monitors();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
